// File: rtl/snes_gamepad_device.sv
// SNES controller device side: samples the console latch and shift clock,
// parallel-loads the button state while latched, then shifts it out LSB-first
// on each console clock rising edge. Wire data is active-low.
module snes_gamepad_device #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] buttons,
  input  logic        snes_latch,
  input  logic        snes_clk,
  output logic        snes_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t state;
  state_t next_state;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   latch_d;
  logic                   clk_d;
  logic                   latch_s;
  logic                   clk_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   clk_rise;

  logic [15:0] shift_reg;
  logic [3:0]  bit_cnt;

  // Synchronize the console pins and keep one extra flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      latch_sync <= '0;
      clk_sync   <= '1;
      latch_d    <= 1'b0;
      clk_d      <= 1'b1;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], snes_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], snes_clk};
      latch_d    <= latch_s;
      clk_d      <= clk_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_d;
  assign latch_fall = ~latch_s & latch_d;
  assign clk_rise   = clk_s & ~clk_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; SHIFT and DONE are only ever entered with the latch low,
  // so any latch high seen there starts with latch_rise
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (latch_s) next_state = LOAD;
      LOAD:    if (latch_fall) next_state = SHIFT;
      SHIFT: begin
        if (latch_rise) begin
          next_state = LOAD;
        end else if (clk_rise && (bit_cnt == 4'd15)) begin
          next_state = DONE;
        end
      end
      DONE:    if (latch_rise) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Shift register, bit counter and registered status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg  <= 16'hFFFF;
      bit_cnt    <= 4'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      busy       <= (next_state == LOAD) || (next_state == SHIFT);
      frame_done <= (state == SHIFT) && (next_state == DONE);
      case (state)
        LOAD: begin
          shift_reg <= ~buttons;
          bit_cnt   <= 4'd0;
        end
        SHIFT: begin
          // A latch arriving with the clock edge discards the shift
          if (clk_rise && !latch_rise) begin
            shift_reg <= {1'b0, shift_reg[15:1]};
            bit_cnt   <= (bit_cnt == 4'd15) ? 4'd0 : bit_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Serial data output per state
  always_comb begin
    snes_data = 1'b1;
    case (state)
      IDLE:    snes_data = 1'b1;
      LOAD:    snes_data = shift_reg[0];
      SHIFT:   snes_data = shift_reg[0];
      DONE:    snes_data = 1'b0;
      default: snes_data = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_snes_gamepad_device.sv
// Bench for snes_gamepad_device: drives console latch/clock waveforms, queues
// the expected wire bit for every clock pulse, and a monitor compares the data
// line at each console falling edge against the queue.
module tb_snes_gamepad_device;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] buttons = 16'h0000;
  logic        snes_latch = 1'b0;
  logic        snes_clk = 1'b1;
  logic        snes_data;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  bit fd_prev = 1'b0;
  bit exp_q[$];

  snes_gamepad_device #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .buttons    (buttons),
    .snes_latch (snes_latch),
    .snes_clk   (snes_clk),
    .snes_data  (snes_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Console samples the data line on its falling clock edge
  always @(negedge snes_clk) begin
    bit e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sample_unexpected: got %b expected no sample at %0t", snes_data, $time);
    end else begin
      e = exp_q.pop_front();
      if (snes_data !== e) begin
        errors++;
        $display("FAIL serial_bit: got %b expected %b at %0t", snes_data, e, $time);
      end
    end
  end

  // Count frame_done pulses and insist each is exactly one cycle wide
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_count++;
      checks++;
      if (fd_prev) begin
        errors++;
        $display("FAIL frame_done_width: got 2+ cycles expected 1 at %0t", $time);
      end
    end
    fd_prev = (frame_done === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_pulse(input int len, input int gap);
    snes_latch = 1'b1;
    cyc(len);
    snes_latch = 1'b0;
    cyc(gap);
  endtask

  task automatic pulse(input bit e, input int h);
    exp_q.push_back(e);
    snes_clk = 1'b0;
    cyc(h);
    snes_clk = 1'b1;
    cyc(h);
  endtask

  task automatic frame(input logic [15:0] btn, input int npulse, input int h);
    for (int i = 0; i < npulse; i++) begin
      pulse((i < 16) ? ~btn[i] : 1'b0, h);
    end
  endtask

  localparam int H = 20;

  initial begin
    int fd0;

    // Reset state
    rst = 1'b0;
    cyc(4);
    check("reset_data", 16'(snes_data), 16'h1);
    check("reset_busy", 16'(busy), 16'h0);
    check("reset_frame_done", 16'(frame_done), 16'h0);
    rst = 1'b1;
    cyc(2);

    // Full frame at real console timing: 12 us latch, 6 us half periods
    buttons = 16'h0001;
    fd0 = fd_count;
    latch_pulse(1200, 600);
    frame(16'h0001, 16, 600);
    cyc(10);
    check("full_frame_done", 16'(fd_count - fd0), 16'd1);
    check("full_busy_low", 16'(busy), 16'h0);
    check("full_done_data", 16'(snes_data), 16'h0);

    // Pattern frame plus a 17th pulse that must read pressed
    buttons = 16'hA5C3;
    fd0 = fd_count;
    latch_pulse(40, H);
    frame(16'hA5C3, 17, H);
    check("pattern_frame_done", 16'(fd_count - fd0), 16'd1);

    // Latch latency and transparent load
    buttons = 16'h1234;
    fd0 = fd_count;
    snes_latch = 1'b1;
    cyc(2);
    check("latency_busy_T2", 16'(busy), 16'h0);
    cyc(1);
    check("latency_busy_T3", 16'(busy), 16'h1);
    cyc(2);
    check("load_data_1234", 16'(snes_data), 16'h1);
    buttons = 16'h0001;
    cyc(1);
    check("transparent_to_0001", 16'(snes_data), 16'h0);
    buttons = 16'h1234;
    cyc(1);
    check("transparent_to_1234", 16'(snes_data), 16'h1);
    snes_latch = 1'b0;
    cyc(H);
    frame(16'h1234, 16, H);
    check("latency_frame_done", 16'(fd_count - fd0), 16'd1);

    // Mid-frame latch after 7 pulses restarts the frame
    buttons = 16'h0F0F;
    fd0 = fd_count;
    latch_pulse(40, H);
    frame(16'h0F0F, 7, H);
    buttons = 16'hC3A5;
    snes_latch = 1'b1;
    cyc(40);
    check("midframe_busy", 16'(busy), 16'h1);
    check("midframe_no_done", 16'(fd_count - fd0), 16'd0);
    snes_latch = 1'b0;
    cyc(H);
    frame(16'hC3A5, 16, H);
    check("midframe_frame_done", 16'(fd_count - fd0), 16'd1);

    // Latch rise and clock rise reach the pins together
    buttons = 16'h00FF;
    fd0 = fd_count;
    latch_pulse(40, H);
    frame(16'h00FF, 3, H);
    exp_q.push_back(~buttons[3]);
    snes_clk = 1'b0;
    cyc(H);
    buttons = 16'h7E81;
    snes_latch = 1'b1;
    snes_clk = 1'b1;
    cyc(40);
    check("simul_busy", 16'(busy), 16'h1);
    check("simul_load_data", 16'(snes_data), 16'h0);
    snes_latch = 1'b0;
    cyc(H);
    frame(16'h7E81, 16, H);
    check("simul_frame_done", 16'(fd_count - fd0), 16'd1);

    // Reset asserted after the 5th pulse aborts the frame
    buttons = 16'h5555;
    fd0 = fd_count;
    latch_pulse(40, H);
    frame(16'h5555, 5, H);
    rst = 1'b0;
    cyc(2);
    check("midreset_data", 16'(snes_data), 16'h1);
    check("midreset_busy", 16'(busy), 16'h0);
    check("midreset_frame_done", 16'(frame_done), 16'h0);
    rst = 1'b1;
    cyc(5);
    check("postreset_idle_data", 16'(snes_data), 16'h1);
    check("postreset_no_done", 16'(fd_count - fd0), 16'd0);
    buttons = 16'h9A6B;
    latch_pulse(40, H);
    frame(16'h9A6B, 16, H);
    check("postreset_frame_done", 16'(fd_count - fd0), 16'd1);

    cyc(5);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snes_gamepad_device.md
SNES_GAMEPAD_DEVICE -- requirements
Module: snes_gamepad_device

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, synchronizer depth for snes_latch and snes_clk; legal range 2-4.
REQ-002 Port: clk  input  1  100 MHz system clock; the only clock in the block.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: buttons  input  16  live button state, active-high (1 = pressed); bit 0 is sent first on the wire.
REQ-005 Port: snes_latch  input  1  console latch; asynchronous to clk; active-high.
REQ-006 Port: snes_clk  input  1  console shift clock; asynchronous to clk; idles high.
REQ-007 Port: snes_data  output  1  serial data to console; active-low on the wire (0 = pressed).
REQ-008 Port: busy  output  1  high in states LOAD and SHIFT.
REQ-009 Port: frame_done  output  1  one-cycle pulse when the 16th bit has been shifted.

Function
REQ-010 snes_latch and snes_clk SHALL each pass through a SYNC_STAGES flop synchronizer, followed by one edge-detect flop.
REQ-011 Edge detection SHALL produce latch_rise, latch_fall and clk_rise, each one clk cycle wide.
REQ-012 Pin-to-action latency SHALL be exactly SYNC_STAGES+1 clk cycles.
REQ-013 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE, with 2-bit encoding. Any unused encoding SHALL go to IDLE.
REQ-014 IDLE: snes_data = 1. On synchronized latch high, the FSM SHALL go to LOAD.
REQ-015 LOAD: on every cycle, shift_reg[15:0] SHALL be loaded with ~buttons, giving transparent parallel load while the latch is high.
REQ-016 LOAD: snes_data SHALL equal shift_reg[0].
REQ-017 LOAD: on latch_fall, the FSM SHALL go to SHIFT with bit_cnt = 0.
REQ-018 SHIFT: shift_reg SHALL hold between clk_rise events.
REQ-019 SHIFT: on clk_rise, shift_reg SHALL shift right with 0 filled into bit 15, and bit_cnt SHALL increment.
REQ-020 SHIFT: snes_data SHALL equal shift_reg[0] at all times, so it changes only after a clk_rise.
REQ-021 SHIFT: when clk_rise occurs with bit_cnt = 15, the FSM SHALL go to DONE, pulse frame_done for one cycle, and set bit_cnt to 0.
REQ-022 DONE: snes_data SHALL be 0, so the line reads "pressed" for bits 17 and beyond. Extra clk_rise events SHALL be ignored.
REQ-023 bit_cnt SHALL be 4 bits wide and SHALL never wrap past 15 inside SHIFT.
REQ-024 In SHIFT or DONE, synchronized latch high SHALL force LOAD immediately; a mid-frame latch restarts the frame.
REQ-025 If latch_rise and clk_rise occur in the same cycle, the latch SHALL win and the shift SHALL be discarded.
REQ-026 In LOAD, clk_rise SHALL be ignored.
REQ-027 busy SHALL be registered and aligned with the state register.

Reset
REQ-028 While rst = 0 on a clk edge, the block SHALL set: state = IDLE, shift_reg = 16'hFFFF, bit_cnt = 0.
REQ-029 While rst = 0 on a clk edge, the latch synchronizer flops SHALL reset to 0 and the clk synchronizer flops SHALL reset to 1.
REQ-030 While rst = 0 on a clk edge, outputs SHALL be: snes_data = 1, busy = 0, frame_done = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; the first valid frame after release SHALL start at a latch high.

Verification
REQ-032 Full frame: buttons = 16'h0001, 12 us latch, then 16 clock pulses of 6 us low / 6 us high.
- snes_data reads 0 at the first falling edge and 1 at the next 15.
- frame_done pulses once.
- busy returns to 0.
REQ-033 Pattern: buttons = 16'hA5C3.
- The 16 serial samples at falling edges are LSB-first ~16'hA5C3 = 16'h5A3C.
- A 17th pulse reads 0.
REQ-034 Latency: snes_latch rises at cycle T with SYNC_STAGES = 2.
- busy rises at T+3.
- A buttons change while the latch is high appears on snes_data within 1 cycle.
REQ-035 Mid-frame latch: latch rises after 7 clock pulses.
- shift_reg reloads and bit_cnt = 0.
- No frame_done occurs.
- The next 16 pulses deliver the full frame.
REQ-036 Simultaneous: latch rise and clk rise reach the pins on the same cycle.
- The state goes to LOAD with no shift.
- The first bit after latch fall is bit 0.
REQ-037 Reset: rst = 0 held 2 cycles after the 5th pulse.
- snes_data = 1, busy = 0.
- A subsequent complete frame is correct.
